// File: rtl/erx_protocol_pkg.sv
// erx_protocol_pkg
//   Shared elink packet field offsets and helpers for the RX protocol stage.
//   The field layout is fixed at 104 bits:
//     [0] access, [1] write, [3:2] datamode, [7:4] ctrlmode,
//     [39:8] dstaddr, [71:40] data, [103:72] srcaddr
package erx_protocol_pkg;

  localparam int E_ACCESS   = 0;
  localparam int E_WRITE    = 1;
  localparam int E_DATAMODE = 2;
  localparam int E_CTRLMODE = 4;
  localparam int E_DSTADDR  = 8;
  localparam int E_DATA     = 40;
  localparam int E_SRCADDR  = 72;

  localparam logic [1:0] DATAMODE_DOUBLE = 2'b11;

  // Burst beats are always 64-bit double writes, so the address advances by 8.
  localparam int BURST_STRIDE = 8;

  // A burst continuation is only meaningful after a header has been seen and
  // only for double-word writes.
  function automatic logic burst_legal(input logic hdr_valid,
                                       input logic write,
                                       input logic [1:0] datamode);
    return hdr_valid && write && (datamode == DATAMODE_DOUBLE);
  endfunction

endpackage

// File: rtl/erx_protocol_fifo_sync.sv
// fifo_sync
//   Single-clock FIFO with registered storage and first-word-fallthrough
//   read data. A push while full is accepted only if a pop happens in the
//   same cycle. Reset empties the FIFO; storage itself is not cleared.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, din         write request and data
//   pop               read request (ignored when empty)
//   dout              head entry (valid while empty is low)
//   full, empty       status flags
//   count             current occupancy (0..DEPTH)
module fifo_sync #(
  parameter int DW    = 104,
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH),
  localparam int CW   = PTRW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_pop;
  logic            do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // Full is fine as long as a slot is freed in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/erx_protocol.sv
// erx_protocol
//   Receive-side protocol stage behind the elink RX deserializer. Captures
//   incoming packets, rebuilds the destination address of burst beats,
//   buffers packets toward the erx core and drives pushback to the I/O stage.
// Ports:
//   rx_lclk_div4, reset        clock, synchronous active-high reset
//   rx_access, rx_burst        incoming packet valid / burst continuation
//   rx_packet                  incoming packet
//   rx_wr_wait, rx_rd_wait     registered pushback to the I/O stage
//   erx_access, erx_packet     outgoing packet (head of FIFO)
//   erx_wait                   downstream stall
//   burst_err, overflow        sticky error flags
//   pkt_count                  packets accepted into the FIFO (wrapping)
module erx_protocol
  import erx_protocol_pkg::*;
#(
  parameter int PW    = 104,
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          rx_lclk_div4,
  input  logic          reset,
  input  logic          rx_access,
  input  logic          rx_burst,
  input  logic [PW-1:0] rx_packet,
  output logic          rx_wr_wait,
  output logic          rx_rd_wait,
  output logic          erx_access,
  output logic [PW-1:0] erx_packet,
  input  logic          erx_wait,
  output logic          burst_err,
  output logic          overflow,
  output logic [15:0]   pkt_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          s1_valid;
  logic [PW-1:0] s1_packet;
  logic [AW-1:0] last_addr;
  logic          hdr_valid;

  logic [AW-1:0] in_addr;
  logic          burst_ok;
  logic [AW-1:0] next_addr;
  logic [PW-1:0] cap_packet;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_dout;
  logic          pop;
  logic          accepted;
  logic          near_full;

  // Illegal bursts keep their received address so the core sees the raw value.
  always_comb begin
    in_addr    = rx_packet[E_DSTADDR +: AW];
    burst_ok   = burst_legal(hdr_valid, rx_packet[E_WRITE],
                             rx_packet[E_DATAMODE +: 2]);
    next_addr  = (rx_burst && burst_ok) ? last_addr + AW'(BURST_STRIDE) : in_addr;
    cap_packet = rx_packet;
    cap_packet[E_DSTADDR +: AW] = next_addr;
  end

  // S1 capture register plus burst address tracking.
  always_ff @(posedge rx_lclk_div4) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_packet <= '0;
      last_addr <= '0;
      hdr_valid <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      s1_valid <= rx_access;
      if (rx_access) begin
        s1_packet <= cap_packet;
        last_addr <= next_addr;
        hdr_valid <= 1'b1;
        if (rx_burst && !burst_ok) burst_err <= 1'b1;
      end
    end
  end

  assign erx_access = !fifo_empty;
  assign pop        = erx_access && !erx_wait;
  assign accepted   = s1_valid && (!fifo_full || pop);
  // Two slots of margin cover the packets already in the I/O stage and S1.
  assign near_full  = (fifo_count >= CW'(DEPTH - 2));
  // Gate the head so stale storage never shows on the output after reset.
  assign erx_packet = erx_access ? fifo_dout : '0;

  fifo_sync #(
    .DW    (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rx_lclk_div4),
    .reset (reset),
    .push  (s1_valid),
    .pop   (pop),
    .din   (s1_packet),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Counters, sticky overflow and registered pushback.
  always_ff @(posedge rx_lclk_div4) begin
    if (reset) begin
      pkt_count  <= '0;
      overflow   <= 1'b0;
      rx_wr_wait <= 1'b0;
      rx_rd_wait <= 1'b0;
    end else begin
      if (accepted) pkt_count <= pkt_count + 16'd1;
      if (s1_valid && !accepted) overflow <= 1'b1;
      rx_wr_wait <= near_full;
      rx_rd_wait <= near_full || erx_wait;
    end
  end

endmodule

// File: tb/tb_erx_protocol.sv
// tb_erx_protocol
//   Randomized and directed stimulus for erx_protocol, compared every cycle
//   against a queue-based reference model of the packet flow.
module tb_erx_protocol;

  localparam int PW    = 104;
  localparam int DEPTH = 4;

  logic          rx_lclk_div4 = 1'b0;
  logic          reset        = 1'b1;
  logic          rx_access    = 1'b0;
  logic          rx_burst     = 1'b0;
  logic [PW-1:0] rx_packet    = '0;
  logic          erx_wait     = 1'b0;
  logic          rx_wr_wait;
  logic          rx_rd_wait;
  logic          erx_access;
  logic [PW-1:0] erx_packet;
  logic          burst_err;
  logic          overflow;
  logic [15:0]   pkt_count;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [PW-1:0] m_fifo [$];
  logic          m_stage_valid = 1'b0;
  logic [PW-1:0] m_stage       = '0;
  logic [31:0]   m_last        = '0;
  logic          m_hdr         = 1'b0;
  logic          m_berr        = 1'b0;
  logic          m_ovf         = 1'b0;
  logic [15:0]   m_cnt         = '0;
  logic          m_wr_wait     = 1'b0;
  logic          m_rd_wait     = 1'b0;

  // Destination addresses of packets actually popped from the DUT.
  logic [31:0]   seen [$];

  erx_protocol #(.PW(PW), .DEPTH(DEPTH), .AW(32)) dut (
    .rx_lclk_div4 (rx_lclk_div4),
    .reset        (reset),
    .rx_access    (rx_access),
    .rx_burst     (rx_burst),
    .rx_packet    (rx_packet),
    .rx_wr_wait   (rx_wr_wait),
    .rx_rd_wait   (rx_rd_wait),
    .erx_access   (erx_access),
    .erx_packet   (erx_packet),
    .erx_wait     (erx_wait),
    .burst_err    (burst_err),
    .overflow     (overflow),
    .pkt_count    (pkt_count)
  );

  always #5 rx_lclk_div4 = ~rx_lclk_div4;

  task automatic checkOutput(input string tag, input logic [PW-1:0] actual,
                             input logic [PW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [PW-1:0] makePkt(input logic write, input logic [1:0] dm,
                                            input logic [31:0] addr);
    logic [PW-1:0] p;
    logic [3:0]    ctrl;
    ctrl     = 4'($urandom);
    p        = '0;
    p[0]     = 1'b1;
    p[1]     = write;
    p[3:2]   = dm;
    p[7:4]   = ctrl;
    p[39:8]  = addr;
    p[71:40] = $urandom;
    p[103:72] = $urandom;
    return p;
  endfunction

  // Advance the model by one rising edge using the inputs now on the pins.
  task automatic modelEdge();
    int            occ;
    logic          pop;
    logic [31:0]   addr;
    logic [PW-1:0] pkt;
    if (reset) begin
      m_fifo.delete();
      m_stage_valid = 1'b0;
      m_stage = '0;
      m_last = '0;
      m_hdr = 1'b0;
      m_berr = 1'b0;
      m_ovf = 1'b0;
      m_cnt = '0;
      m_wr_wait = 1'b0;
      m_rd_wait = 1'b0;
    end else begin
      occ = m_fifo.size();
      pop = (occ > 0) && !erx_wait;
      m_wr_wait = (occ >= DEPTH - 2);
      m_rd_wait = m_wr_wait || erx_wait;
      if (pop) void'(m_fifo.pop_front());
      if (m_stage_valid) begin
        if (occ < DEPTH || pop) begin
          m_fifo.push_back(m_stage);
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_stage_valid = rx_access;
      if (rx_access) begin
        pkt  = rx_packet;
        addr = pkt[39:8];
        if (rx_burst) begin
          if (m_hdr && pkt[1] && pkt[3:2] == 2'b11) addr = m_last + 32'd8;
          else m_berr = 1'b1;
        end
        m_last = addr;
        m_hdr = 1'b1;
        pkt[39:8] = addr;
        m_stage = pkt;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("erx_access", PW'(erx_access), PW'(m_fifo.size() > 0));
    checkOutput("erx_packet", erx_packet, (m_fifo.size() > 0) ? m_fifo[0] : '0);
    checkOutput("rx_wr_wait", PW'(rx_wr_wait), PW'(m_wr_wait));
    checkOutput("rx_rd_wait", PW'(rx_rd_wait), PW'(m_rd_wait));
    checkOutput("burst_err", PW'(burst_err), PW'(m_berr));
    checkOutput("overflow", PW'(overflow), PW'(m_ovf));
    checkOutput("pkt_count", PW'(pkt_count), PW'(m_cnt));
  endtask

  // Drive one cycle of inputs from the falling edge, then check the result.
  task automatic applyStimulus(input logic acc, input logic burst,
                               input logic [PW-1:0] pkt, input logic wt);
    if (erx_access === 1'b1 && !wt && !reset) seen.push_back(erx_packet[39:8]);
    rx_access = acc;
    rx_burst  = burst;
    rx_packet = pkt;
    erx_wait  = wt;
    @(posedge rx_lclk_div4);
    modelEdge();
    @(negedge rx_lclk_div4);
    checkAll();
  endtask

  task automatic idle(input int n, input logic wt);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, wt);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    seen.delete();
  endtask

  logic [PW-1:0] p;
  logic [31:0]   a;

  initial begin
    // Reset values.
    doReset();
    doReset();

    // Single write: output two cycles after capture, bit-identical.
    p = makePkt(1'b1, 2'b10, 32'h8000_0000);
    applyStimulus(1'b1, 1'b0, p, 1'b0);
    checkOutput("lat_n1", PW'(erx_access), PW'(1'b0));
    idle(1, 1'b0);
    checkOutput("lat_n2", PW'(erx_access), PW'(1'b1));
    checkOutput("single_pkt", erx_packet, p);
    checkOutput("single_cnt", PW'(pkt_count), PW'(16'd1));
    idle(2, 1'b0);

    // Header plus three legal burst beats.
    doReset();
    applyStimulus(1'b1, 1'b0, makePkt(1'b1, 2'b11, 32'h100), 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, makePkt(1'b1, 2'b11, 32'hDEAD_0000), 1'b0);
    idle(4, 1'b0);
    checkOutput("burst_n", PW'(seen.size()), PW'(4));
    for (int i = 0; i < 4 && i < seen.size(); i++)
      checkOutput("burst_addr", PW'(seen[i]), PW'(32'h100 + 32'(8 * i)));
    checkOutput("burst_ok", PW'(burst_err), PW'(1'b0));

    // Burst as first packet after reset.
    doReset();
    applyStimulus(1'b1, 1'b1, makePkt(1'b1, 2'b11, 32'h2000), 1'b0);
    idle(3, 1'b0);
    checkOutput("berr_first", PW'(burst_err), PW'(1'b1));
    checkOutput("berr_first_addr", PW'(seen.size() > 0 ? seen[0] : 32'hX), PW'(32'h2000));

    // Burst carrying a read.
    doReset();
    applyStimulus(1'b1, 1'b0, makePkt(1'b1, 2'b11, 32'h300), 1'b0);
    applyStimulus(1'b1, 1'b1, makePkt(1'b0, 2'b11, 32'h500), 1'b0);
    applyStimulus(1'b1, 1'b1, makePkt(1'b1, 2'b11, 32'h0), 1'b0);
    idle(4, 1'b0);
    checkOutput("berr_read", PW'(burst_err), PW'(1'b1));
    checkOutput("berr_read_addr", PW'(seen.size() > 1 ? seen[1] : 32'hX), PW'(32'h500));
    checkOutput("berr_after_addr", PW'(seen.size() > 2 ? seen[2] : 32'hX), PW'(32'h508));

    // Overflow with the output stalled.
    doReset();
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, makePkt(1'b1, 2'b10, 32'h1000 + 32'(16 * i)), 1'b1);
    idle(1, 1'b1);
    checkOutput("ovf_flag", PW'(overflow), PW'(1'b1));
    checkOutput("ovf_cnt", PW'(pkt_count), PW'(16'd4));
    checkOutput("ovf_wait", PW'(rx_wr_wait), PW'(1'b1));
    idle(6, 1'b0);
    checkOutput("ovf_out_n", PW'(seen.size()), PW'(4));
    for (int i = 0; i < 4 && i < seen.size(); i++)
      checkOutput("ovf_order", PW'(seen[i]), PW'(32'h1000 + 32'(16 * i)));

    // Address wrap on a burst beat.
    doReset();
    applyStimulus(1'b1, 1'b0, makePkt(1'b1, 2'b11, 32'hFFFF_FFF8), 1'b0);
    applyStimulus(1'b1, 1'b1, makePkt(1'b1, 2'b11, 32'h1234), 1'b0);
    idle(3, 1'b0);
    checkOutput("wrap_addr", PW'(seen.size() > 1 ? seen[1] : 32'hX), PW'(32'h0));

    // Reset with packets buffered discards everything.
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, makePkt(1'b1, 2'b01, 32'h40), 1'b1);
    idle(1, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, makePkt(1'b1, 2'b11, 32'h77), 1'b0);
    reset = 1'b0;
    checkOutput("rst_access", PW'(erx_access), PW'(1'b0));
    checkOutput("rst_berr", PW'(burst_err), PW'(1'b0));
    checkOutput("rst_cnt", PW'(pkt_count), PW'(16'd0));
    idle(2, 1'b0);
    checkOutput("rst_after", PW'(erx_access), PW'(1'b0));

    // Randomized traffic: mostly legal bursts, random stalls, one reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset = 1'b1;
      a = $urandom;
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                    makePkt(($urandom_range(0, 15) != 0),
                            ($urandom_range(0, 7) != 0) ? 2'b11 : 2'($urandom),
                            a),
                    ($urandom_range(0, 2) == 0));
      reset = 1'b0;
    end
    idle(8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
